// File: rtl/mips32_pkg.sv
// Shared constants for the memory dump engine.
//   DEF_ADDR_W / DEF_DATA_W : default word-address and data widths.
//   ST_* : FSM state encodings used by mips32_mem_dump.
package mips32_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_READ = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT = 3'd2;
    localparam logic [STATE_W-1:0] ST_SEND = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

endpackage

// File: rtl/mips32_word_serializer.sv
// Holds one 32-bit word and presents it as four bytes, MSB first.
//   clk_i, rst_i : clock and asynchronous active-high reset
//   load_i       : capture word_i and restart at byte 0
//   word_i       : word to serialize
//   shift_i      : current byte accepted; advance to the next one
//   byte_o       : byte currently presented (bits [31:24] of the register)
//   byte_idx_o   : index 0..3 of the byte currently presented
module mips32_word_serializer
    import mips32_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [DEF_DATA_W-1:0] word_i,
    input  logic                  shift_i,
    output logic [7:0]            byte_o,
    output logic [1:0]            byte_idx_o
);

    logic [DEF_DATA_W-1:0] shreg_q, shreg_d;
    logic [1:0]            idx_q, idx_d;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load_i) begin
            shreg_d = word_i;
            idx_d   = 2'd0;
        end else if (shift_i) begin
            shreg_d = {shreg_q[23:0], 8'h00};
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    assign byte_o     = shreg_q[31:24];
    assign byte_idx_o = idx_q;

endmodule

// File: rtl/mips32_mem_dump.sv
// Streams a block of core-memory words out as a byte stream, MSB first.
//   clk1, rst                : clock and asynchronous active-high reset
//   start, base_addr,
//   word_count               : dump request, sampled only while idle
//   busy, done               : not-idle flag and one-cycle completion pulse
//   mem_rd_en, mem_addr,
//   mem_rd_data              : core memory read port (data one cycle after strobe)
//   tx_valid, tx_ready,
//   tx_data, tx_last         : byte stream with valid/ready handshake
//
// state | meaning
// IDLE  | waiting for start
// READ  | read strobe for the current word address
// WAIT  | read data arrives; load it into the serializer
// SEND  | present four bytes, one per handshake
// DONE  | one-cycle done pulse
module mips32_mem_dump
    import mips32_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_last
);

    localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    remain_q, remain_d;

    logic       ser_load;
    logic       ser_shift;
    logic [7:0] ser_byte;
    logic [1:0] ser_idx;
    logic       last_word;
    logic       last_byte;

    // remain_q counts the current word too, so 1 means this is the final word
    assign last_word = (remain_q == ONE_WORD);
    assign last_byte = (ser_idx == 2'd3);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = word_count;
                    state_d  = (word_count == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_SEND;
            ST_SEND: begin
                if (tx_ready && last_byte) begin
                    if (last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d   = addr_q + 1'b1;   // wraps naturally at 2^ADDR_W
                        remain_d = remain_q - ONE_WORD;
                        state_d  = ST_READ;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    assign ser_load  = (state_q == ST_WAIT);
    assign ser_shift = (state_q == ST_SEND) && tx_ready;

    mips32_word_serializer u_ser (
        .clk_i      (clk1),
        .rst_i      (rst),
        .load_i     (ser_load),
        .word_i     (mem_rd_data),
        .shift_i    (ser_shift),
        .byte_o     (ser_byte),
        .byte_idx_o (ser_idx)
    );

    // Outputs decode directly from reset-cleared registers so reset takes effect at once
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mem_rd_en = (state_q == ST_READ);
    assign mem_addr  = addr_q;
    assign tx_valid  = (state_q == ST_SEND);
    assign tx_data   = tx_valid ? ser_byte : 8'h00;
    assign tx_last   = tx_valid && last_byte && last_word;

endmodule

// File: tb/tb_mips32_mem_dump.sv
module tb_mips32_mem_dump;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        busy, done, mem_rd_en, tx_valid, tx_ready, tx_last;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic [7:0]  tx_data;

    logic [31:0] mem [0:1023];

    mips32_mem_dump #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk1        (clk1),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_last     (tx_last)
    );

    always #5 clk1 = ~clk1;

    // Core memory model: registered read, data valid one cycle after the strobe
    always @(posedge clk1) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Results of the most recent dump
    logic [7:0]  bytes_q [$];
    logic [9:0]  rd_q [$];
    logic [31:0] exp_words [$];
    int last_idx, n_last, first_valid, done_idx, stable_err, n_valid;
    logic busy_at_done;

    // Indices k count negedges after the edge that samples start (k=0 is the first)
    task automatic run_dump(input logic [9:0] base, input logic [10:0] cnt, input bit toggle,
                            input int poke_at, input int rst_after, input int budget);
        logic [7:0] held;
        bit stalled;
        bytes_q.delete();
        rd_q.delete();
        last_idx = -1; n_last = 0; first_valid = -1; done_idx = -1;
        stable_err = 0; n_valid = 0; stalled = 0; busy_at_done = 1'b0; held = 8'h00;
        @(posedge clk1); #1;
        base_addr = base; word_count = cnt; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        if (toggle) tx_ready = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk1);
            if (tx_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = k;
                if (stalled && tx_data !== held) stable_err++;
                if (tx_ready) begin
                    bytes_q.push_back(tx_data);
                    if (tx_last) begin
                        n_last++;
                        last_idx = bytes_q.size() - 1;
                    end
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = tx_data;
                end
            end else if (stalled) begin
                stable_err++;
            end
            if (mem_rd_en) rd_q.push_back(mem_addr);
            if (k == poke_at) begin
                start = 1'b1; base_addr = 10'h043; word_count = 11'd1;
            end
            if (done) begin
                done_idx = k;
                busy_at_done = busy;
                break;
            end
            @(posedge clk1); #1;
            start = 1'b0;
            if (toggle) tx_ready = ~tx_ready;
            if (rst_after > 0 && bytes_q.size() == rst_after) begin
                rst = 1'b1;
                #1;
                return;
            end
        end
        if (start) begin
            @(posedge clk1); #1;
            start = 1'b0;
        end
    endtask

    task automatic check_bytes(input string tag);
        int n;
        n = exp_words.size() * 4;
        check({tag, "_nbytes"}, 32'(bytes_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            logic [7:0]  e, g;
            w = exp_words[i / 4];
            e = w[31 - 8 * (i % 4) -: 8];
            g = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(e));
        end
    endtask

    task automatic check_after_done(input string tag);
        @(negedge clk1);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int quiet_busy, quiet_valid, quiet_rd;
        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; tx_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        #2;
        check("reset_outputs", 32'({busy, done, mem_rd_en, tx_valid, tx_last, tx_data, mem_addr}), 32'd0);
        repeat (3) @(posedge clk1);
        #1 rst = 1'b0;

        // Two words with a start pulse during SEND that must be ignored
        mem[10'h023] = 32'd1;
        mem[10'h024] = 32'd11;
        run_dump(10'h023, 11'd2, 1'b0, 4, 0, 40);
        exp_words = '{32'h0000_0001, 32'h0000_000B};
        check_bytes("t1");
        check("t1_first_valid", 32'(first_valid), 32'd2);
        check("t1_last_idx", 32'(last_idx), 32'd7);
        check("t1_n_last", 32'(n_last), 32'd1);
        check("t1_done_idx", 32'(done_idx), 32'd12);
        check("t1_nreads", 32'(rd_q.size()), 32'd2);
        check("t1_addr0", 32'(rd_q[0]), 32'h023);
        check("t1_addr1", 32'(rd_q[1]), 32'h024);
        check_after_done("t1");

        // Address wrap 0x3FF -> 0x000
        mem[10'h3FF] = 32'hDEAD_BEEF;
        mem[10'h000] = 32'h2019_0200;
        run_dump(10'h3FF, 11'd2, 1'b0, -1, 0, 40);
        exp_words = '{32'hDEAD_BEEF, 32'h2019_0200};
        check_bytes("t2");
        check("t2_nreads", 32'(rd_q.size()), 32'd2);
        check("t2_addr0", 32'(rd_q[0]), 32'h3FF);
        check("t2_addr1", 32'(rd_q[1]), 32'h000);
        check("t2_last_idx", 32'(last_idx), 32'd7);
        check("t2_done_idx", 32'(done_idx), 32'd12);
        check_after_done("t2");

        // Back-pressure: tx_ready toggling every cycle
        mem[10'h043] = 32'd22;
        run_dump(10'h043, 11'd1, 1'b1, -1, 0, 40);
        exp_words = '{32'h0000_0016};
        check_bytes("t3");
        check("t3_stable", 32'(stable_err), 32'd0);
        check("t3_last_idx", 32'(last_idx), 32'd3);
        check("t3_n_last", 32'(n_last), 32'd1);
        check_after_done("t3");

        // Zero-length dump, with a start pulse while busy in DONE
        run_dump(10'h100, 11'd0, 1'b0, 0, 0, 10);
        check("t4_done_idx", 32'(done_idx), 32'd0);
        check("t4_busy_in_done", 32'(busy_at_done), 32'd1);
        check("t4_no_valid", 32'(n_valid), 32'd0);
        check("t4_no_reads", 32'(rd_q.size()), 32'd0);
        check_after_done("t4");
        quiet_busy = 0; quiet_valid = 0; quiet_rd = 0;
        repeat (6) begin
            @(negedge clk1);
            if (busy) quiet_busy++;
            if (tx_valid) quiet_valid++;
            if (mem_rd_en) quiet_rd++;
        end
        check("t4_restart_ignored", 32'(quiet_busy + quiet_valid + quiet_rd), 32'd0);

        // Reset in the middle of a four-word dump
        mem[10'h050] = 32'h1122_3344;
        mem[10'h051] = 32'h5566_7788;
        mem[10'h052] = 32'h99AA_BBCC;
        mem[10'h053] = 32'hDDEE_FF00;
        run_dump(10'h050, 11'd4, 1'b0, -1, 2, 40);
        check("t5_rst_outputs", 32'({busy, done, mem_rd_en, tx_valid, tx_last, tx_data, mem_addr}), 32'd0);
        check("t5_pre_rst_bytes", 32'({bytes_q[0], bytes_q[1]}), 32'h1122);
        @(posedge clk1); #1;
        rst = 1'b0;
        quiet_busy = 0; quiet_valid = 0;
        repeat (5) begin
            @(negedge clk1);
            if (busy) quiet_busy++;
            if (tx_valid) quiet_valid++;
        end
        check("t5_quiet_after_rst", 32'(quiet_busy + quiet_valid), 32'd0);
        mem[10'h044] = 32'd33;
        run_dump(10'h044, 11'd1, 1'b0, -1, 0, 40);
        exp_words = '{32'h0000_0021};
        check_bytes("t5");
        check("t5_done_idx", 32'(done_idx), 32'd6);
        check("t5_addr0", 32'(rd_q[0]), 32'h044);
        check_after_done("t5");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
